// File: rtl/ppm_decoder.sv
// 4-PPM frame decoder: SOF lock, four 2-bit symbols (LSB pair first), EOF check, byte out.
// Latency: data_valid 3 clocks after the EOF rising edge on Din (2 sync flops + 1 decode).
// No backpressure: the sink must take data_out on the data_valid strobe; optional err_cnt via PPM_DEC_ERR_CNT_EN.
module ppm_decoder #(
  parameter int CHIP = 16,
  parameter int TOL  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
`ifdef PPM_DEC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SOF1, SOF_GAP, SOF2, DATA, EOF, DONE} state_t;

  // Frame-counter checkpoints, relative to the first SOF falling edge.
  localparam logic [9:0] P1_LO = 10'(CHIP - TOL);
  localparam logic [9:0] P1_HI = 10'(CHIP + TOL);
  localparam logic [9:0] G_LO  = 10'(5*CHIP - TOL);
  localparam logic [9:0] G_HI  = 10'(5*CHIP + TOL);
  localparam logic [9:0] P2_LO = 10'(6*CHIP - TOL);
  localparam logic [9:0] P2_HI = 10'(6*CHIP + TOL);
  localparam logic [9:0] SLOT0 = 10'(8*CHIP);
  localparam logic [9:0] REARM = 10'(4*CHIP - 1);
  // Slot / EOF window offsets and pulse width limits.
  localparam logic [6:0] O_LAST = 7'(8*CHIP - 1);
  localparam logic [6:0] E_LO   = 7'(2*CHIP - TOL);
  localparam logic [6:0] E_HI   = 7'(2*CHIP + TOL);
  localparam logic [6:0] W_LO   = 7'(CHIP - TOL);
  localparam logic [6:0] W_HI   = 7'(CHIP + TOL);

  state_t     state, nxt;
  logic       sync1, s, s_prev;
  logic       fe, re;
  logic [9:0] fc, hcnt;
  logic [6:0] o, w;
  logic [1:0] k, sym;
  logic [7:0] sr;
  logic       got, low, eof_fall, armed;
  logic       hit, accept, eaccept, err, done;
  logic       in_slots, w_ok, w_tmo;

  assign fe       = s_prev & ~s;
  assign re       = ~s_prev & s;
  assign in_slots = (fc >= SLOT0);
  assign w_ok     = (w >= W_LO) && (w <= W_HI);
  // A pulse still low at the maximum width can only end too late.
  assign w_tmo    = low && !re && (w >= W_HI);
  assign busy     = (state != IDLE);

  // Map the current slot offset to the symbol whose pulse position it matches.
  always_comb begin
    hit = 1'b0;
    sym = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if ((o >= 7'((2*v+1)*CHIP - TOL)) && (o <= 7'((2*v+1)*CHIP + TOL))) begin
        hit = 1'b1;
        sym = 2'(v);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state, edge acceptance and error detection.
  always_comb begin
    nxt     = state;
    err     = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    eaccept = 1'b0;
    case (state)
      IDLE: if (fe && armed) nxt = SOF1;
      SOF1: begin
        // A short low run is line noise, not a frame: drop it without an error.
        if (re) nxt = (fc < P1_LO) ? IDLE : SOF_GAP;
        else if (fc >= P1_HI) err = 1'b1;
      end
      SOF_GAP: begin
        if (fe) begin
          if (fc < G_LO) err = 1'b1;
          else           nxt = SOF2;
        end else if (fc >= G_HI) err = 1'b1;
      end
      SOF2: begin
        if (re) begin
          if (fc < P2_LO) err = 1'b1;
          else            nxt = DATA;
        end else if (fc >= P2_HI) err = 1'b1;
      end
      DATA: begin
        if ((low && re && !w_ok) || w_tmo) err = 1'b1;
        if (fe) begin
          if (!in_slots || got || !hit) err = 1'b1;
          else                          accept = 1'b1;
        end
        if (in_slots && (o == O_LAST)) begin
          if (!(got || accept)) err = 1'b1;
          else if (k == 2'd3)   nxt = EOF;
        end
      end
      EOF: begin
        // A slot-3 pulse may still be finishing here; its width is checked the same way.
        if ((low && re && !w_ok) || w_tmo) err = 1'b1;
        if (fe) begin
          if (eof_fall || (o < E_LO) || (o > E_HI)) err = 1'b1;
          else                                     eaccept = 1'b1;
        end else if (!eof_fall && (o >= E_HI)) err = 1'b1;
        if (low && re && w_ok && eof_fall) begin
          done = 1'b1;
          nxt  = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (err) begin
      nxt     = IDLE;
      done    = 1'b0;
      accept  = 1'b0;
      eaccept = 1'b0;
    end
  end

  // Synchronizer, counters, symbol assembly, re-arm tracking and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      s          <= 1'b1;
      s_prev     <= 1'b1;
      fc         <= '0;
      o          <= '0;
      k          <= '0;
      w          <= '0;
      hcnt       <= '0;
      sr         <= '0;
      got        <= 1'b0;
      low        <= 1'b0;
      eof_fall   <= 1'b0;
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PPM_DEC_ERR_CNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      sync1      <= Din;
      s          <= sync1;
      s_prev     <= s;
      data_valid <= done;
      frame_err  <= err;
      if (done) data_out <= sr;

      fc <= (nxt == IDLE) ? 10'd0 : fc + 10'd1;

      // Slot offset is pinned to 0 until the first slot starts at 8*CHIP.
      if ((state == DATA) && in_slots) begin
        if (o == O_LAST) begin
          o <= '0;
          k <= k + 2'd1;
        end else begin
          o <= o + 7'd1;
        end
      end else if (state == EOF) begin
        o <= o + 7'd1;
      end else begin
        o <= '0;
        k <= '0;
      end

      got <= ((state == DATA) && in_slots && (o != O_LAST)) ? (got | accept) : 1'b0;
      if (accept) sr[{k, 1'b0} +: 2] <= sym;

      // Pulse-width tracker: w counts clocks since the accepted falling edge.
      if (nxt == IDLE) begin
        low <= 1'b0;
        w   <= '0;
      end else if (accept || eaccept) begin
        low <= 1'b1;
        w   <= 7'd1;
      end else if (low && re) begin
        low <= 1'b0;
      end else if (low) begin
        w <= w + 7'd1;
      end

      eof_fall <= (nxt == EOF) && (eof_fall || eaccept);

      // After an error, stay deaf until the line has idled high long enough.
      if (err) begin
        armed <= 1'b0;
        hcnt  <= '0;
      end else if ((state == IDLE) && !armed) begin
        if (!s)                 hcnt <= '0;
        else if (hcnt == REARM) begin
          armed <= 1'b1;
          hcnt  <= '0;
        end else                hcnt <= hcnt + 10'd1;
      end

`ifdef PPM_DEC_ERR_CNT_EN
      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
`endif
    end
  end

endmodule
